// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Holds the default divisor width and the FSM state encoding used by
// div8x4_seq. The sub-module and the interface take their default width from here.
package div_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div8x4_seq_if.sv
// Handshake/data bundle for div8x4_seq.
//   start       : request a division (master -> slave)
//   dividend    : 2N-bit unsigned dividend (master -> slave)
//   divisor     : N-bit unsigned divisor (master -> slave)
//   quotient    : 2N-bit registered quotient (slave -> master)
//   remainder   : N-bit registered remainder (slave -> master)
//   busy        : operation in progress (slave -> master)
//   done        : result valid (slave -> master)
//   div_by_zero : captured divisor was 0, valid with done (slave -> master)
interface div8x4_seq_if #(
    parameter int N = div_pkg::DIV_N
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/div8x4_seq_step.sv
// One restoring-division step (purely combinational).
//   shifted  : partial remainder already shifted left with the next dividend bit
//   divisor  : N-bit unsigned divisor
//   rem_next : shifted - divisor when that does not go negative, else shifted
//   qbit     : 1 when the subtraction was kept
module div_step #(
    parameter int N = div_pkg::DIV_N
) (
    input  logic [N:0]   shifted,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_next,
    output logic         qbit
);

    // One extra bit so the borrow of the trial subtraction is visible.
    logic [N+1:0] diff;

    always_comb begin
        diff     = {1'b0, shifted} - {2'b00, divisor};
        qbit     = ~diff[N+1];
        rem_next = qbit ? diff[N:0] : shifted;
    end

endmodule

// File: rtl/div8x4_seq.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor, restoring
// algorithm, one quotient bit per clock, MSB first.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div8x4_seq_if slave modport (start/operands in, results/status out)
// A zero divisor skips the iterations and reports all-ones / 0 with
// div_by_zero one clock after the start. Result registers only update when
// an operation finishes, so partial values never reach the outputs.
module div8x4_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    div8x4_seq_if.slave  bus
);

    localparam int             CW       = $clog2(2*N);
    localparam logic [CW-1:0]  CNT_INIT = CW'(2*N-1);

    div_state_e      state;
    logic [2*N-1:0]  q_work;     // dividend bits shift out the top, quotient bits in the bottom
    logic [N-1:0]    dsr;
    logic [N:0]      prem;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  quotient_r;
    logic [N-1:0]    remainder_r;
    logic            busy_r;
    logic            done_r;
    logic            dbz_r;

    logic [N:0]      shifted;
    logic [N:0]      rem_next;
    logic            qbit;
    logic [2*N-1:0]  q_next;

    // prem never exceeds the divisor, so its top bit drops off in the shift.
    assign shifted = (N+1)'({prem, q_work[2*N-1]});
    assign q_next  = {q_work[2*N-2:0], qbit};

    div_step #(.N(N)) u_step (
        .shifted  (shifted),
        .divisor  (dsr),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_work      <= '0;
            dsr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (busy_r) begin
                        // Only reachable in DONE: a zero-divisor start finishes
                        // here, one clock after it was accepted.
                        quotient_r  <= '1;
                        remainder_r <= '0;
                        dbz_r       <= 1'b1;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (bus.start) begin
                        q_work <= bus.dividend;
                        dsr    <= bus.divisor;
                        prem   <= '0;
                        cnt    <= CNT_INIT;
                        done_r <= 1'b0;
                        dbz_r  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= (bus.divisor == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    prem   <= rem_next;
                    q_work <= q_next;
                    if (cnt == '0) begin
                        quotient_r  <= q_next;
                        remainder_r <= rem_next[N-1:0];
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

endmodule
